perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
//  Owns and updates the eight performance counters decoded on the low 32 bytes of MMIO space.
//  - Counts I-cache, D-cache and L1->L2 accesses, plus the cycles each access is outstanding.
//  - Counts branch predictions and mispredictions.
//  - Responder side of the counter window: registered read data, write-to-clear.
//  - Sits beside the cache hierarchy; event strobes come from cache/arbiter handshakes and the EX stage.
// PARAMETERS
//  CNT_W       32  counter width; counters saturate at all-ones (bench overrides to 4)
//  WIN_BYTES   32  MMIO window size; addr < WIN_BYTES belongs to this block
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      synchronous active-low reset
//  i_read         in   1      I-cache request held until i_resp
//  i_resp         in   1      I-cache response, 1-cycle pulse
//  d_req          in   1      D-cache read|write request held until d_resp
//  d_resp         in   1      D-cache response, 1-cycle pulse
//  l2_req         in   1      L1->L2 arbiter request held until l2_resp
//  l2_resp        in   1      L2 response, 1-cycle pulse
//  br_valid       in   1      resolved branch this cycle
//  br_mispredict  in   1      qualifies br_valid
//  mmio_addr      in   32     byte address from MEM stage
//  mmio_read      in   1      read strobe
//  mmio_write     in   1      write strobe (data ignored)
//  mmio_rdata     out  CNT_W  selected counter, registered
//  mmio_resp      out  1      1-cycle pulse, cycle after accepted read or write
// BEHAVIOUR
//  - Counter map, index = addr[4:2]:
//    0 i_access, 1 d_access, 2 l2_access, 3 i_cycles,
//    4 d_cycles, 5 l2_cycles, 6 predictions, 7 mispredictions.
//  - Reset (rst_n=0 at clk edge): all counters 0, all port FSMs IDLE, mmio_rdata=0, mmio_resp=0.
//    Reset mid-access abandons the access; no partial counts survive.
//  - Port FSM, one each for i/d/l2, states IDLE, BUSY:
//    IDLE & req & resp : access+1, cycles+1, stay IDLE (single-cycle hit)
//    IDLE & req & !resp: access+1, cycles+1, go BUSY
//    BUSY & !resp      : cycles+1
//    BUSY & resp       : cycles+1, go IDLE
//    IDLE & resp & !req: ignored
//  - Back-to-back: req still high in the cycle after resp starts a new access.
//  - Cycles count = request duration inclusive of the resp cycle.
//  - br_valid: predictions+1. br_valid & br_mispredict: mispredictions+1.
//    br_mispredict without br_valid is ignored.
//  - All increments saturate at 2^CNT_W-1 and never wrap.
//  - Accepted access = mmio_read|mmio_write with mmio_addr < WIN_BYTES. Other addresses: no effect, no resp.
//  - Read: mmio_rdata <= counter[addr[4:2]] value before this cycle's update; mmio_resp=1 next cycle.
//  - Write: counter[addr[4:2]] <= 0. Clear beats a same-cycle increment; the increment is lost.
//    Port FSM state is unaffected, so a BUSY access keeps counting cycles from 0 after the clear.
//  - Read and write together: the write is honoured; mmio_rdata returns the pre-clear value.
//  - mmio_rdata holds its last value when no read is accepted.
//  - addr[1:0] is ignored.
// TESTING
//  1. Reset, then read 0x00..0x1C -> each read gives mmio_resp the next cycle and rdata=0.
//  2. i_read high 3 cycles, i_resp in cycle 3 -> read 0x00 = 1, read 0x0C = 3.
//  3. d_req high 2 cycles with d_resp both cycles (two hits) -> read 0x04 = 2, read 0x10 = 2.
//  4. CNT_W=4, br_valid for 20 cycles, br_mispredict on 5 of them -> read 0x18 = 15, read 0x1C = 5.
//  5. Write 0x1C in the same cycle as br_valid&br_mispredict, prior count 5 -> next read 0x1C = 0.
//  6. Read 0x20 -> no mmio_resp, rdata unchanged.
//     Assert rst_n=0 during a BUSY l2 access -> all counters 0, the later l2_resp is ignored.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Eight saturating performance counters (cache accesses/outstanding cycles, branch stats)
// exposed through a small MMIO window with registered read data and write-to-clear.
module perf_counter_bank #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned WIN_BYTES = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_read,
  input  logic             i_resp,
  input  logic             d_req,
  input  logic             d_resp,
  input  logic             l2_req,
  input  logic             l2_resp,
  input  logic             br_valid,
  input  logic             br_mispredict,
  input  logic [31:0]      mmio_addr,
  input  logic             mmio_read,
  input  logic             mmio_write,
  output logic [CNT_W-1:0] mmio_rdata,
  output logic             mmio_resp
);

  localparam int unsigned N_CNT = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam int unsigned I_ACCESS  = 0;
  localparam int unsigned D_ACCESS  = 1;
  localparam int unsigned L2_ACCESS = 2;
  localparam int unsigned I_CYCLES  = 3;
  localparam int unsigned D_CYCLES  = 4;
  localparam int unsigned L2_CYCLES = 5;
  localparam int unsigned PREDICTS  = 6;
  localparam int unsigned MISPREDS  = 7;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } port_state_t;

  port_state_t i_state, d_state, l2_state;

  logic [N_CNT-1:0] inc;
  logic [CNT_W-1:0] cnt [N_CNT];
  logic [IDX_W-1:0] sel;
  logic             win_hit;
  logic             rd_acc;
  logic             wr_acc;

  // A request seen in IDLE opens an access; resp closes it (possibly in the same cycle).
  function automatic port_state_t port_next(input port_state_t st, input logic req,
                                            input logic resp);
    port_state_t nxt;
    nxt = st;
    case (st)
      IDLE: if (req && !resp) nxt = BUSY;
      BUSY: if (resp) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_state  <= IDLE;
      d_state  <= IDLE;
      l2_state <= IDLE;
    end else begin
      i_state  <= port_next(i_state, i_read, i_resp);
      d_state  <= port_next(d_state, d_req, d_resp);
      l2_state <= port_next(l2_state, l2_req, l2_resp);
    end
  end

  // Cycles count for every cycle of an access, so BUSY or a fresh request both qualify.
  always_comb begin
    inc            = '0;
    inc[I_ACCESS]  = (i_state == IDLE) && i_read;
    inc[D_ACCESS]  = (d_state == IDLE) && d_req;
    inc[L2_ACCESS] = (l2_state == IDLE) && l2_req;
    inc[I_CYCLES]  = (i_state == BUSY) || i_read;
    inc[D_CYCLES]  = (d_state == BUSY) || d_req;
    inc[L2_CYCLES] = (l2_state == BUSY) || l2_req;
    inc[PREDICTS]  = br_valid;
    inc[MISPREDS]  = br_valid && br_mispredict;
  end

  always_comb begin
    sel     = mmio_addr[4:2];
    win_hit = mmio_addr < 32'(WIN_BYTES);
    rd_acc  = mmio_read && win_hit;
    wr_acc  = mmio_write && win_hit;
  end

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CNT; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CNT; i++) begin
        if (wr_acc && (sel == IDX_W'(i))) begin
          cnt[i] <= '0;
        end else if (inc[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mmio_rdata <= '0;
      mmio_resp  <= 1'b0;
    end else begin
      mmio_resp <= rd_acc || wr_acc;
      if (rd_acc) mmio_rdata <= cnt[sel];
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank with CNT_W=4: stimulus pushes expected
// responses, a negedge monitor pops and compares whenever mmio_resp is seen.
module tb_perf_counter_bank;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             i_read, i_resp, d_req, d_resp, l2_req, l2_resp;
  logic             br_valid, br_mispredict;
  logic [31:0]      mmio_addr;
  logic             mmio_read, mmio_write;
  logic [CNT_W-1:0] mmio_rdata;
  logic             mmio_resp;

  perf_counter_bank #(.CNT_W(CNT_W), .WIN_BYTES(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_resp       (i_resp),
    .d_req        (d_req),
    .d_resp       (d_resp),
    .l2_req       (l2_req),
    .l2_resp      (l2_resp),
    .br_valid     (br_valid),
    .br_mispredict(br_mispredict),
    .mmio_addr    (mmio_addr),
    .mmio_read    (mmio_read),
    .mmio_write   (mmio_write),
    .mmio_rdata   (mmio_rdata),
    .mmio_resp    (mmio_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [CNT_W-1:0] exp_q [$];
  string            name_q [$];
  logic [CNT_W-1:0] exp_hold;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (mmio_resp) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 1, 0);
      end else begin
        check(name_q.pop_front(), int'(mmio_rdata), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_rd(input logic [31:0] addr, input logic [CNT_W-1:0] exp,
                         input string name);
    mmio_addr = addr;
    mmio_read = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
    exp_hold = exp;
    tick();
    mmio_read = 1'b0;
  endtask

  task automatic mmio_wr(input logic [31:0] addr, input string name);
    mmio_addr  = addr;
    mmio_write = 1'b1;
    exp_q.push_back(exp_hold);
    name_q.push_back(name);
    tick();
    mmio_write = 1'b0;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    tick();
    rst_n    = 1'b1;
    exp_hold = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    {i_read, i_resp, d_req, d_resp, l2_req, l2_resp} = '0;
    {br_valid, br_mispredict, mmio_read, mmio_write} = '0;
    mmio_addr = '0;
    exp_hold  = '0;
    tick();
    do_reset();
    check("reset_resp", int'(mmio_resp), 0);
    check("reset_rdata", int'(mmio_rdata), 0);

    // 1: all counters zero after reset
    for (int i = 0; i < 8; i++) mmio_rd(32'(i * 4), '0, $sformatf("reset_cnt%0d", i));

    // 2: three-cycle I-cache access
    i_read = 1'b1;
    tick();
    tick();
    i_resp = 1'b1;
    tick();
    i_read = 1'b0;
    i_resp = 1'b0;
    mmio_rd(32'h00, 4'd1, "i_access");
    mmio_rd(32'h0C, 4'd3, "i_cycles");
    mmio_rd(32'h0E, 4'd3, "i_cycles_low_bits_ignored");

    // 3: two back-to-back single-cycle D-cache hits
    d_req  = 1'b1;
    d_resp = 1'b1;
    tick();
    tick();
    d_req  = 1'b0;
    d_resp = 1'b0;
    mmio_rd(32'h04, 4'd2, "d_access");
    mmio_rd(32'h10, 4'd2, "d_cycles");

    // 4: saturating prediction counter
    for (int i = 0; i < 20; i++) begin
      br_valid      = 1'b1;
      br_mispredict = (i % 4 == 0);
      tick();
    end
    br_valid      = 1'b0;
    br_mispredict = 1'b1;
    tick();
    br_mispredict = 1'b0;
    mmio_rd(32'h18, 4'd15, "predictions_sat");
    mmio_rd(32'h1C, 4'd5, "mispredictions");

    // 5: clear wins over same-cycle increment
    br_valid      = 1'b1;
    br_mispredict = 1'b1;
    mmio_wr(32'h1C, "clear_mispred_resp");
    br_valid      = 1'b0;
    br_mispredict = 1'b0;
    mmio_rd(32'h1C, 4'd0, "mispred_after_clear");
    mmio_rd(32'h18, 4'd15, "predictions_kept");

    // read+write together returns pre-clear value
    mmio_addr  = 32'h00;
    mmio_read  = 1'b1;
    mmio_write = 1'b1;
    exp_q.push_back(4'd1);
    name_q.push_back("rw_preclear");
    exp_hold = 4'd1;
    tick();
    mmio_read  = 1'b0;
    mmio_write = 1'b0;
    mmio_rd(32'h00, 4'd0, "rw_cleared");

    // clear during a BUSY l2 access restarts cycle count from zero
    l2_req = 1'b1;
    tick();
    tick();
    mmio_wr(32'h14, "clear_l2_cycles_resp");
    tick();
    l2_resp = 1'b1;
    tick();
    l2_req  = 1'b0;
    l2_resp = 1'b0;
    mmio_rd(32'h14, 4'd2, "l2_cycles_after_clear");
    mmio_rd(32'h08, 4'd1, "l2_access");

    // 6: out-of-window read
    mmio_addr = 32'h20;
    mmio_read = 1'b1;
    tick();
    mmio_read = 1'b0;
    tick();
    check("oow_rdata_hold", int'(mmio_rdata), int'(exp_hold));
    check("oow_no_pending", exp_q.size(), 0);

    // reset during BUSY l2 access; later resp alone is ignored
    l2_req = 1'b1;
    tick();
    tick();
    l2_req = 1'b0;
    do_reset();
    check("midreset_rdata", int'(mmio_rdata), 0);
    l2_resp = 1'b1;
    tick();
    l2_resp = 1'b0;
    tick();
    mmio_rd(32'h08, 4'd0, "l2_access_after_reset");
    mmio_rd(32'h14, 4'd0, "l2_cycles_after_reset");
    mmio_rd(32'h18, 4'd0, "predictions_after_reset");

    tick();
    tick();
    check("all_resp_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
